// File: rtl/lc3_pkg.sv
// Shared LC-3 memory-sequencer definitions: opcodes, access-stage bus codes
// and the sequencer FSM state type.
package lc3_pkg;

    localparam logic [3:0] OP_LD  = 4'b0010;
    localparam logic [3:0] OP_ST  = 4'b0011;
    localparam logic [3:0] OP_LDR = 4'b0110;
    localparam logic [3:0] OP_STR = 4'b0111;
    localparam logic [3:0] OP_LDI = 4'b1010;
    localparam logic [3:0] OP_STI = 4'b1011;

    localparam logic [1:0] MS_READ  = 2'd0;
    localparam logic [1:0] MS_PTR   = 2'd1;
    localparam logic [1:0] MS_WRITE = 2'd2;
    localparam logic [1:0] MS_IDLE  = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_PTR  = 3'd1,
        ST_RD   = 3'd2,
        ST_WR   = 3'd3,
        ST_DONE = 3'd4
    } lc3_state_e;

    function automatic logic is_indirect(input logic [3:0] op);
        return (op == OP_LDI) || (op == OP_STI);
    endfunction

endpackage

// File: rtl/lc3_mem_sequencer_if.sv
// Request, memory-stage and writeback signals of the LC-3 memory sequencer.
// Handshake: start is only looked at while the sequencer is idle; the requester
// holds its request until done, which pulses for one cycle per accepted request.
interface lc3_mem_sequencer_if;
    import lc3_pkg::*;

    logic        start;
    logic [3:0]  opcode;
    logic [15:0] addr_in;
    logic [15:0] data_in;
    logic [15:0] Data_dout;
    logic [1:0]  mem_state;
    logic        M_Control;
    logic [15:0] M_Addr;
    logic [15:0] M_Data;
    logic        busy;
    logic        done;
    logic [15:0] mem_result;
    logic        illegal;
    lc3_state_e  state_dbg;

    modport slave (
        input  start, opcode, addr_in, data_in, Data_dout,
        output mem_state, M_Control, M_Addr, M_Data, busy, done,
               mem_result, illegal, state_dbg
    );

    modport master (
        output start, opcode, addr_in, data_in, Data_dout,
        input  mem_state, M_Control, M_Addr, M_Data, busy, done,
               mem_result, illegal, state_dbg
    );

endinterface

// File: rtl/lc3_mem_sequencer.sv
// Multi-cycle load/store sequencer feeding the LC-3 memory-access stage.
// Every output is registered; next values are derived from the next FSM state.
module lc3_mem_sequencer
    import lc3_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic                 clock,
    input  logic                 reset,
    lc3_mem_sequencer_if.slave   bus
);

    localparam logic [3:0] LAT_M1 = 4'(MEM_LAT - 1);

    lc3_state_e  r_state, w_state;
    logic [3:0]  r_cnt, w_cnt;
    logic [3:0]  r_op, w_op;
    logic [15:0] r_addr, w_addr;
    logic [15:0] r_data, w_data;
    logic [15:0] r_ptr, w_ptr;
    logic [1:0]  r_mem_state, w_mem_state;
    logic [15:0] r_m_addr, w_m_addr;
    logic [15:0] r_m_data, w_m_data;
    logic        r_busy, w_busy;
    logic        r_done, w_done;
    logic [15:0] r_result, w_result;
    logic        r_illegal, w_illegal;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= 4'd0;
            r_op        <= 4'd0;
            r_addr      <= 16'd0;
            r_data      <= 16'd0;
            r_ptr       <= 16'd0;
            r_mem_state <= MS_IDLE;
            r_m_addr    <= 16'd0;
            r_m_data    <= 16'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_result    <= 16'd0;
            r_illegal   <= 1'b0;
        end else begin
            r_state     <= w_state;
            r_cnt       <= w_cnt;
            r_op        <= w_op;
            r_addr      <= w_addr;
            r_data      <= w_data;
            r_ptr       <= w_ptr;
            r_mem_state <= w_mem_state;
            r_m_addr    <= w_m_addr;
            r_m_data    <= w_m_data;
            r_busy      <= w_busy;
            r_done      <= w_done;
            r_result    <= w_result;
            r_illegal   <= w_illegal;
        end
    end

    always_comb begin
        w_state     = r_state;
        w_cnt       = r_cnt;
        w_op        = r_op;
        w_addr      = r_addr;
        w_data      = r_data;
        w_ptr       = r_ptr;
        w_m_addr    = r_m_addr;
        w_m_data    = r_m_data;
        w_result    = r_result;
        w_illegal   = r_illegal;
        w_mem_state = MS_IDLE;
        w_busy      = 1'b0;
        w_done      = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (bus.start) begin
                    w_op      = bus.opcode;
                    w_addr    = bus.addr_in;
                    w_data    = bus.data_in;
                    w_cnt     = LAT_M1;
                    w_illegal = 1'b0;
                    case (bus.opcode)
                        OP_LD, OP_LDR:  w_state = ST_RD;
                        OP_ST, OP_STR:  w_state = ST_WR;
                        OP_LDI, OP_STI: w_state = ST_PTR;
                        default: begin
                            w_state   = ST_DONE;
                            w_illegal = 1'b1;
                        end
                    endcase
                end
            end
            ST_PTR: begin
                if (r_cnt == 4'd0) begin
                    w_ptr   = bus.Data_dout;
                    w_cnt   = LAT_M1;
                    w_state = (r_op == OP_LDI) ? ST_RD : ST_WR;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            ST_RD: begin
                if (r_cnt == 4'd0) begin
                    w_result = bus.Data_dout;
                    w_state  = ST_DONE;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            ST_WR: begin
                if (r_cnt == 4'd0) begin
                    w_state = ST_DONE;
                end else begin
                    w_cnt = r_cnt - 4'd1;
                end
            end
            ST_DONE: w_state = ST_IDLE;
            default: w_state = ST_IDLE;
        endcase

        // Bus outputs follow the state being entered so they are valid the cycle after the edge.
        case (w_state)
            ST_PTR: begin
                w_mem_state = MS_PTR;
                w_m_addr    = w_addr;
                w_busy      = 1'b1;
            end
            ST_RD: begin
                w_mem_state = MS_READ;
                w_m_addr    = is_indirect(w_op) ? w_ptr : w_addr;
                w_busy      = 1'b1;
            end
            ST_WR: begin
                w_mem_state = MS_WRITE;
                w_m_addr    = is_indirect(w_op) ? w_ptr : w_addr;
                w_m_data    = w_data;
                w_busy      = 1'b1;
            end
            ST_DONE: w_done = 1'b1;
            default: ;
        endcase
    end

    assign bus.mem_state  = r_mem_state;
    assign bus.M_Control  = 1'b0;
    assign bus.M_Addr     = r_m_addr;
    assign bus.M_Data     = r_m_data;
    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.mem_result = r_result;
    assign bus.illegal    = r_illegal;
    assign bus.state_dbg  = r_state;

endmodule

// File: tb/tb_lc3_mem_sequencer.sv
// Scoreboard bench for lc3_mem_sequencer: one instance with MEM_LAT=1 and one
// with MEM_LAT=3, each backed by its own memory model.
module tb_lc3_mem_sequencer;
    import lc3_pkg::*;

    typedef struct packed {
        logic        d;
        logic [1:0]  ms;
        logic [15:0] a;
        logic [15:0] dat;
        logic        chk;
    } bus_t;

    typedef struct packed {
        logic        d;
        logic        ill;
        logic [15:0] res;
        logic [31:0] cyc;
    } done_t;

    logic clock;
    logic reset;
    int   cyc;
    int   vectors;
    int   errors;

    bus_t  exp_bus_q[$];
    done_t exp_done_q[$];

    logic [15:0] mem1 [0:65535];
    logic [15:0] mem3 [0:65535];
    logic        pre_we;
    int          pre_sel;
    logic [15:0] pre_a;
    logic [15:0] pre_d;

    lc3_mem_sequencer_if if1 ();
    lc3_mem_sequencer_if if3 ();

    lc3_mem_sequencer #(.MEM_LAT(1)) u_dut1 (.clock(clock), .reset(reset), .bus(if1.slave));
    lc3_mem_sequencer #(.MEM_LAT(3)) u_dut3 (.clock(clock), .reset(reset), .bus(if3.slave));

    // clock / reset
    initial clock = 1'b0;
    always #5 clock = ~clock;
    initial cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    // memory models
    assign if1.Data_dout = mem1[if1.M_Addr];
    assign if3.Data_dout = mem3[if3.M_Addr];
    always @(posedge clock) begin
        if (if1.mem_state == MS_WRITE) mem1[if1.M_Addr] <= if1.M_Data;
        if (if3.mem_state == MS_WRITE) mem3[if3.M_Addr] <= if3.M_Data;
        if (pre_we && pre_sel == 0) mem1[pre_a] <= pre_d;
        if (pre_we && pre_sel == 1) mem3[pre_a] <= pre_d;
    end

    // monitor / scoreboard
    bus_t        eb;
    done_t       ed;
    logic [1:0]  m_ms;
    logic        m_mc, m_done, m_busy, m_ill;
    logic [15:0] m_addr, m_data, m_res;

    always @(negedge clock) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                m_ms   = (d == 0) ? if1.mem_state  : if3.mem_state;
                m_mc   = (d == 0) ? if1.M_Control  : if3.M_Control;
                m_addr = (d == 0) ? if1.M_Addr     : if3.M_Addr;
                m_data = (d == 0) ? if1.M_Data     : if3.M_Data;
                m_done = (d == 0) ? if1.done       : if3.done;
                m_busy = (d == 0) ? if1.busy       : if3.busy;
                m_res  = (d == 0) ? if1.mem_result : if3.mem_result;
                m_ill  = (d == 0) ? if1.illegal    : if3.illegal;
                if (m_ms != MS_IDLE) begin
                    vectors++;
                    if (exp_bus_q.size() == 0) begin
                        errors++;
                        $display("FAIL bus_unexpected dut%0d cyc %0d: got ms=%0d addr=%h, want no access",
                                 d, cyc, m_ms, m_addr);
                    end else begin
                        eb = exp_bus_q.pop_front();
                        if (eb.d != d[0] || eb.ms != m_ms || eb.a != m_addr || m_mc != 1'b0 ||
                            m_busy != 1'b1 || (eb.chk && eb.dat != m_data)) begin
                            errors++;
                            $display("FAIL bus dut%0d cyc %0d: got ms=%0d addr=%h data=%h mc=%b busy=%b, want dut%0d ms=%0d addr=%h data=%h mc=0 busy=1",
                                     d, cyc, m_ms, m_addr, m_data, m_mc, m_busy, eb.d, eb.ms, eb.a, eb.dat);
                        end
                    end
                end
                if (m_done) begin
                    vectors++;
                    if (exp_done_q.size() == 0) begin
                        errors++;
                        $display("FAIL done_unexpected dut%0d cyc %0d: got done=1, want no done", d, cyc);
                    end else begin
                        ed = exp_done_q.pop_front();
                        if (ed.d != d[0] || ed.ill != m_ill || ed.res != m_res || ed.cyc != 32'(cyc) || m_busy != 1'b0) begin
                            errors++;
                            $display("FAIL done dut%0d: got cyc=%0d illegal=%b result=%h busy=%b, want dut%0d cyc=%0d illegal=%b result=%h busy=0",
                                     d, cyc, m_ill, m_res, m_busy, ed.d, ed.cyc, ed.ill, ed.res);
                        end
                    end
                end
            end
        end
    end

    // driver tasks
    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, want %h", nm, act, exp);
        end
    endtask

    task automatic preload(input int sel, input logic [15:0] a, input logic [15:0] v);
        @(negedge clock);
        pre_we = 1'b1; pre_sel = sel; pre_a = a; pre_d = v;
        @(negedge clock);
        pre_we = 1'b0;
    endtask

    task automatic issue(input int d, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] dat, output int acc);
        @(negedge clock);
        if (d == 0) begin
            if1.start = 1'b1; if1.opcode = op; if1.addr_in = a; if1.data_in = dat;
        end else begin
            if3.start = 1'b1; if3.opcode = op; if3.addr_in = a; if3.data_in = dat;
        end
        @(posedge clock);
        #1;
        acc = cyc;
        if1.start = 1'b0;
        if3.start = 1'b0;
    endtask

    task automatic exp_bus(input int d, input logic [1:0] ms, input logic [15:0] a,
                           input logic [15:0] dat, input logic c, input int n);
        bus_t e;
        e.d = d[0]; e.ms = ms; e.a = a; e.dat = dat; e.chk = c;
        repeat (n) exp_bus_q.push_back(e);
    endtask

    task automatic exp_done(input int d, input logic ill, input logic [15:0] res, input int at);
        done_t e;
        e.d = d[0]; e.ill = ill; e.res = res; e.cyc = 32'(at);
        exp_done_q.push_back(e);
    endtask

    task automatic wait_idle();
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 100 && !ok; i++) begin
            @(posedge clock);
            #1;
            if (exp_bus_q.size() == 0 && exp_done_q.size() == 0) ok = 1'b1;
        end
        if (!ok) begin
            vectors++;
            errors++;
            $display("FAIL timeout: got %0d bus / %0d done pending, want 0",
                     exp_bus_q.size(), exp_done_q.size());
            exp_bus_q.delete();
            exp_done_q.delete();
        end
    endtask

    // stimulus
    initial begin
        int a;
        vectors = 0; errors = 0;
        pre_we = 1'b0; pre_sel = 0; pre_a = 16'h0; pre_d = 16'h0;
        if1.start = 1'b0; if1.opcode = 4'h0; if1.addr_in = 16'h0; if1.data_in = 16'h0;
        if3.start = 1'b0; if3.opcode = 4'h0; if3.addr_in = 16'h0; if3.data_in = 16'h0;
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk("reset_dut1", {if1.mem_state, if1.M_Control, if1.M_Addr, if1.M_Data, if1.busy,
                           if1.done, if1.mem_result, if1.illegal}, {2'd3, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0});
        chk("reset_dut3", {if3.mem_state, if3.M_Control, if3.M_Addr, if3.M_Data, if3.busy,
                           if3.done, if3.mem_result, if3.illegal}, {2'd3, 1'b0, 16'h0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0});
        reset = 1'b0;

        preload(0, 16'h3000, 16'hBEEF);
        preload(0, 16'hFFFF, 16'h7777);
        preload(1, 16'h3010, 16'h5000);
        preload(1, 16'h5000, 16'hCAFE);
        preload(1, 16'h3000, 16'hBEEF);

        // MEM_LAT=1: direct accesses
        issue(0, OP_LD, 16'h3000, 16'h0, a);
        exp_bus(0, MS_READ, 16'h3000, 16'h0, 1'b0, 1);
        exp_done(0, 1'b0, 16'hBEEF, a + 1);
        wait_idle();

        issue(0, OP_ST, 16'h4001, 16'h1234, a);
        exp_bus(0, MS_WRITE, 16'h4001, 16'h1234, 1'b1, 1);
        exp_done(0, 1'b0, 16'hBEEF, a + 1);
        wait_idle();
        chk("st_mem_4001", 64'(mem1[16'h4001]), 64'h1234);

        issue(0, OP_LDR, 16'hFFFF, 16'h0, a);
        exp_bus(0, MS_READ, 16'hFFFF, 16'h0, 1'b0, 1);
        exp_done(0, 1'b0, 16'h7777, a + 1);
        wait_idle();

        issue(0, 4'b0001, 16'h2222, 16'h3333, a);
        exp_done(0, 1'b1, 16'h7777, a);
        wait_idle();
        repeat (2) @(negedge clock);
        chk("illegal_hold", {63'h0, if1.illegal}, 64'h1);

        issue(0, OP_STR, 16'h0000, 16'hA5A5, a);
        exp_bus(0, MS_WRITE, 16'h0000, 16'hA5A5, 1'b1, 1);
        exp_done(0, 1'b0, 16'h7777, a + 1);
        wait_idle();
        chk("str_mem_0000", 64'(mem1[16'h0000]), 64'hA5A5);

        // MEM_LAT=3: indirect accesses, with a start pulse ignored mid-LDI
        issue(1, OP_LDI, 16'h3010, 16'h0, a);
        exp_bus(1, MS_PTR, 16'h3010, 16'h0, 1'b0, 3);
        exp_bus(1, MS_READ, 16'h5000, 16'h0, 1'b0, 3);
        exp_done(1, 1'b0, 16'hCAFE, a + 6);
        @(negedge clock);
        if3.start = 1'b1; if3.opcode = OP_LD; if3.addr_in = 16'h1234;
        @(negedge clock);
        if3.start = 1'b0;
        wait_idle();

        issue(1, OP_STI, 16'h3010, 16'h00AA, a);
        exp_bus(1, MS_PTR, 16'h3010, 16'h0, 1'b0, 3);
        exp_bus(1, MS_WRITE, 16'h5000, 16'h00AA, 1'b1, 3);
        exp_done(1, 1'b0, 16'hCAFE, a + 6);
        wait_idle();
        chk("sti_mem_5000", 64'(mem3[16'h5000]), 64'h00AA);

        issue(1, OP_LD, 16'h5000, 16'h0, a);
        exp_bus(1, MS_READ, 16'h5000, 16'h0, 1'b0, 3);
        exp_done(1, 1'b0, 16'h00AA, a + 3);
        wait_idle();

        // reset during the pointer phase of an LDI
        issue(1, OP_LDI, 16'h3010, 16'h0, a);
        exp_bus(1, MS_PTR, 16'h3010, 16'h0, 1'b0, 1);
        @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("async_reset", {58'h0, if3.mem_state, if3.busy, if3.done, if3.state_dbg},
                           {58'h0, 2'd3, 1'b0, 1'b0, ST_IDLE});
        repeat (2) @(negedge clock);
        reset = 1'b0;
        repeat (6) @(negedge clock);
        chk("abandoned_ptr", 64'(exp_bus_q.size()), 64'h0);

        issue(1, OP_LD, 16'h3000, 16'h0, a);
        exp_bus(1, MS_READ, 16'h3000, 16'h0, 1'b0, 3);
        exp_done(1, 1'b0, 16'hBEEF, a + 3);
        wait_idle();

        repeat (2) @(negedge clock);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
